// File: rtl/register_bank_write_arbiter.sv
// rtl/register_bank_write_arbiter.sv - bank init sweep plus round-robin writeback arbiter
// Owns the register bank write port: sweeps INIT_VALUE after reset, then grants one source per cycle.
module register_bank_write_arbiter #(
  parameter int                    NUM_WB         = 3,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    DEPTH          = 64,
  parameter int                    ALLOW_WRITE_P0 = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE     = '0,
  localparam int                   AW             = $clog2(DEPTH),
  localparam int                   RW             = $clog2(NUM_WB)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_WB-1:0]                   wb_valid,
  input  logic [NUM_WB-1:0][AW-1:0]           wb_addr,
  input  logic [NUM_WB-1:0][DATA_WIDTH-1:0]   wb_data,
  output logic [NUM_WB-1:0]                   wb_ack,
  output logic                                init_done,
  output logic [AW-1:0]                       write_addr,
  output logic [DATA_WIDTH-1:0]               new_data,
  output logic                                commit,
  output logic                                p0_drop
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam logic [AW-1:0] CNT_START = (ALLOW_WRITE_P0 != 0) ? '0 : AW'(1);
  localparam logic [AW-1:0] CNT_LAST  = AW'(DEPTH - 1);
  localparam logic [RW-1:0] RR_RESET  = RW'(NUM_WB - 1);

  state_t                  state_q, state_d;
  logic [AW-1:0]           cnt_q, cnt_d;
  logic [RW-1:0]           rr_q, rr_d;
  logic                    init_done_q, init_done_d;
  logic [AW-1:0]           write_addr_q, write_addr_d;
  logic [DATA_WIDTH-1:0]   new_data_q, new_data_d;
  logic                    commit_q, commit_d;
  logic                    p0_drop_q, p0_drop_d;

  logic                    grant_vld;
  logic [RW-1:0]           grant_idx;
  logic [RW-1:0]           cand;

  // Search starts just after the last winner; gated until init_done so the sweep owns the port.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = rr_q;
    cand      = '0;
    for (int k = 1; k <= NUM_WB; k++) begin
      cand = RW'((int'(rr_q) + k) % NUM_WB);
      if (!grant_vld && wb_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    if (!init_done_q) begin
      grant_vld = 1'b0;
    end
  end

  always_comb begin
    wb_ack = '0;
    if (grant_vld) begin
      wb_ack[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rr_d         = rr_q;
    init_done_d  = init_done_q;
    write_addr_d = write_addr_q;
    new_data_d   = new_data_q;
    commit_d     = 1'b0;
    p0_drop_d    = 1'b0;
    if (state_q == ST_INIT) begin
      commit_d     = 1'b1;
      write_addr_d = cnt_q;
      new_data_d   = INIT_VALUE;
      // Counter parks on the last entry instead of wrapping back to 0.
      if (cnt_q == CNT_LAST) begin
        state_d = ST_RUN;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      init_done_d = 1'b1;
      if (grant_vld) begin
        rr_d         = grant_idx;
        write_addr_d = wb_addr[grant_idx];
        new_data_d   = wb_data[grant_idx];
        // Writes to entry 0 are acked but dropped, never stalled.
        if ((ALLOW_WRITE_P0 == 0) && (wb_addr[grant_idx] == '0)) begin
          p0_drop_d = 1'b1;
        end else begin
          commit_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_INIT;
      cnt_q        <= CNT_START;
      rr_q         <= RR_RESET;
      init_done_q  <= 1'b0;
      write_addr_q <= '0;
      new_data_q   <= '0;
      commit_q     <= 1'b0;
      p0_drop_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rr_q         <= rr_d;
      init_done_q  <= init_done_d;
      write_addr_q <= write_addr_d;
      new_data_q   <= new_data_d;
      commit_q     <= commit_d;
      p0_drop_q    <= p0_drop_d;
    end
  end

  assign init_done  = init_done_q;
  assign write_addr = write_addr_q;
  assign new_data   = new_data_q;
  assign commit     = commit_q;
  assign p0_drop    = p0_drop_q;

  a_ack_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(wb_ack));
  a_no_ack_in_init: assert property (@(posedge clk) disable iff (rst) !init_done_q |-> (wb_ack == '0));
  a_no_p0_commit: assert property (@(posedge clk) disable iff (rst)
    !((ALLOW_WRITE_P0 == 0) && commit_q && (write_addr_q == '0)));

endmodule
